hub_xfer: RTL and testbench

HUB_XFER -- requirements
Module: hub_xfer

---
 rtl/hub_xfer.sv | 227 ++++++++++++++++++++++
 tb/tb_hub_xfer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_xfer.sv
// hub_xfer: cog-side hub bus transfer engine.
// Takes a byte/word/long burst command, requests the shared hub bus in this
// port's slot, advances the address per beat, and returns read data through
// a one-deep valid/ready response register. A per-beat watchdog abandons a
// burst whose acknowledge never arrives.
module hub_xfer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        ena_bus,
    input  logic        bus_sel,
    output logic        bus_r,
    output logic        bus_e,
    output logic        bus_w,
    output logic [1:0]  bus_s,
    output logic [15:0] bus_a,
    output logic [31:0] bus_d,
    input  logic [31:0] bus_q,
    input  logic        bus_ack,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [1:0]  cmd_size,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [7:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BAD  = 2'b11;
    // Last watchdog count before the beat is declared lost.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    // Address increment for one beat of the given transfer size.
    function automatic logic [15:0] addr_step(input logic [1:0] size);
        logic [15:0] step;
        case (size)
            2'b00:   step = 16'd1;
            2'b01:   step = 16'd2;
            2'b10:   step = 16'd4;
            default: step = 16'd0;
        endcase
        return step;
    endfunction

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        slot_s;

    // The phase strobe carries no information this port needs: slot
    // ownership is fully described by bus_sel.
    logic unused_ena_s;
    assign unused_ena_s = ena_bus;

    assign slot_s = (state_q == ST_REQ) && bus_sel;

    // Drive the OR-combined hub bus only while requesting in our own slot.
    always_comb begin
        if (slot_s) begin
            bus_r = 1'b1;
            bus_e = 1'b1;
            bus_w = wr_q;
            bus_s = size_q;
            bus_a = addr_q;
            bus_d = wr_q ? data_q : 32'd0;
        end else begin
            bus_r = 1'b0;
            bus_e = 1'b0;
            bus_w = 1'b0;
            bus_s = 2'b00;
            bus_a = 16'd0;
            bus_d = 32'd0;
        end
    end

    // Next-state logic: command intake, beat completion, hold and watchdog.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        wdog_d     = wdog_q;
        rsp_data_d = rsp_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // A consumer handshake frees the response register; a read beat
        // loading below overrides this in the same cycle.
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_size == SIZE_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        wr_d    = cmd_wr;
                        size_d  = cmd_size;
                        addr_d  = cmd_addr;
                        data_d  = cmd_data;
                        cnt_d   = cmd_len;
                        wdog_d  = 8'd0;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    wdog_d = 8'd0;
                    if (!wr_q) begin
                        rsp_data_d  = bus_q;
                        rsp_valid_d = 1'b1;
                    end else begin
                        rsp_data_d = rsp_data_q;
                    end
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_q + addr_step(size_q);
                        // Do not start another read while the fresh data
                        // has nowhere to go.
                        if (!wr_q && !rsp_ready) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                    wdog_d  = 8'd0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    state_d = ST_REQ;
                    wdog_d  = 8'd0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE) || rsp_valid_d;
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 16'd0;
            data_q      <= 32'd0;
            cnt_q       <= 8'd0;
            wdog_q      <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hub_xfer.sv
// Self-checking bench for hub_xfer: directed scenarios plus randomized
// bursts checked against a beat-level transfer model.
module tb_hub_xfer;

    logic        clk_cog = 1'b0;
    logic        nres = 1'b0;
    logic        ena_bus = 1'b0;
    logic        bus_sel = 1'b0;
    logic        bus_r, bus_e, bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;
    logic [31:0] bus_q = 32'd0;
    logic        bus_ack = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [1:0]  cmd_size = 2'b00;
    logic [15:0] cmd_addr = 16'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy, done, err;
    logic [52:0] bus_all;

    int checks = 0;
    int errors = 0;

    hub_xfer #(.TIMEOUT(8)) dut (
        .clk_cog(clk_cog), .nres(nres), .ena_bus(ena_bus), .bus_sel(bus_sel),
        .bus_r(bus_r), .bus_e(bus_e), .bus_w(bus_w), .bus_s(bus_s),
        .bus_a(bus_a), .bus_d(bus_d), .bus_q(bus_q), .bus_ack(bus_ack),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_len(cmd_len), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_cog = ~clk_cog;

    assign bus_all = {bus_r, bus_e, bus_w, bus_s, bus_a, bus_d};

    // Advance to the next negedge, where inputs change and outputs are read.
    task automatic next_cycle();
        @(negedge clk_cog);
        ena_bus = ~ena_bus;
    endtask

    // Present one command for one cycle; returns at the first burst cycle.
    task automatic issue(input logic wr, input logic [1:0] size, input logic [15:0] addr,
                         input logic [31:0] data, input logic [7:0] len);
        next_cycle();
        cmd_valid = 1'b1; cmd_wr = wr; cmd_size = size;
        cmd_addr = addr; cmd_data = data; cmd_len = len;
        next_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        nres = 1'b0; cmd_valid = 1'b1; cmd_size = 2'b10; bus_sel = 1'b1; bus_ack = 1'b1;
        next_cycle(); next_cycle(); #1;
        checks++; if (bus_all !== 53'd0) begin errors++; $display("FAIL rst_bus got=%h exp=0", bus_all); end
        checks++; if ({cmd_ready, rsp_valid, done, err, busy} !== 5'd0) begin errors++;
            $display("FAIL rst_flags got=%b exp=00000", {cmd_ready, rsp_valid, done, err, busy}); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rsp_data); end
        next_cycle(); nres = 1'b1; cmd_valid = 1'b0; cmd_size = 2'b00; bus_ack = 1'b0;
        next_cycle(); #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
        checks++; if (bus_all !== 53'd0) begin errors++; $display("FAIL rst_idle_bus got=%h exp=0", bus_all); end
        bus_sel = 1'b0;
    endtask

    task automatic test_read_long();
        rsp_ready = 1'b0;
        issue(1'b0, 2'b10, 16'h0100, 32'h0, 8'd0);
        bus_sel = 1'b1; bus_ack = 1'b1; bus_q = 32'hDEADBEEF; #1;
        checks++; if (bus_all !== {1'b1, 1'b1, 1'b0, 2'b10, 16'h0100, 32'h0}) begin errors++;
            $display("FAIL rdl_bus got=%h exp=%h", bus_all, {1'b1, 1'b1, 1'b0, 2'b10, 16'h0100, 32'h0}); end
        checks++; if ({cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL rdl_busy got=%b exp=01", {cmd_ready, busy}); end
        next_cycle(); bus_sel = 1'b0; bus_ack = 1'b0; bus_q = 32'h0; #1;
        checks++; if ({rsp_valid, done} !== 2'b11) begin errors++; $display("FAIL rdl_done got=%b exp=11", {rsp_valid, done}); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rdl_data got=%h exp=deadbeef", rsp_data); end
        next_cycle(); rsp_ready = 1'b1; #1;
        checks++; if ({rsp_valid, done} !== 2'b10) begin errors++; $display("FAIL rdl_pulse got=%b exp=10", {rsp_valid, done}); end
        next_cycle(); rsp_ready = 1'b0; #1;
        checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin errors++;
            $display("FAIL rdl_end got=%b exp=001", {rsp_valid, busy, cmd_ready}); end
    endtask

    task automatic test_write_burst();
        logic [15:0] exp_a;
        issue(1'b1, 2'b01, 16'hFFFE, 32'h00001234, 8'd2);
        for (int b = 0; b < 3; b++) begin
            bus_sel = 1'b0; bus_ack = 1'b0; #1;
            checks++; if (bus_all !== 53'd0) begin errors++; $display("FAIL wrb_gate%0d got=%h exp=0", b, bus_all); end
            checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL wrb_busy%0d got=%b exp=10", b, {busy, done}); end
            next_cycle(); bus_sel = 1'b1; bus_ack = 1'b1; #1;
            exp_a = 16'((65534 + 2 * b) % 65536);
            checks++; if (bus_all !== {1'b1, 1'b1, 1'b1, 2'b01, exp_a, 32'h00001234}) begin errors++;
                $display("FAIL wrb_beat%0d got=%h exp=%h", b, bus_all, {1'b1, 1'b1, 1'b1, 2'b01, exp_a, 32'h00001234}); end
            next_cycle();
        end
        bus_sel = 1'b0; bus_ack = 1'b0; #1;
        checks++; if ({done, busy, rsp_valid} !== 3'b100) begin errors++;
            $display("FAIL wrb_done got=%b exp=100", {done, busy, rsp_valid}); end
        next_cycle(); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrb_pulse got=%b exp=0", done); end
    endtask

    task automatic test_read_hold();
        logic [31:0] d[4];
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        rsp_ready = 1'b0;
        issue(1'b0, 2'b00, 16'h0010, 32'h0, 8'd3);
        bus_sel = 1'b1; bus_ack = 1'b1; bus_q = d[0]; #1;
        checks++; if (bus_all !== {1'b1, 1'b1, 1'b0, 2'b00, 16'h0010, 32'h0}) begin errors++;
            $display("FAIL hold_beat0 got=%h", bus_all); end
        for (int k = 0; k < 4; k++) begin
            next_cycle(); bus_q = $urandom; #1;
            checks++; if (bus_all !== 53'd0) begin errors++; $display("FAIL hold_nobus%0d got=%h exp=0", k, bus_all); end
            checks++; if ({rsp_valid, busy, done} !== 3'b110 || rsp_data !== d[0]) begin errors++;
                $display("FAIL hold_rsp%0d got=%b/%h exp=110/%h", k, {rsp_valid, busy, done}, rsp_data, d[0]); end
        end
        next_cycle(); rsp_ready = 1'b1; bus_ack = 1'b0; #1;
        checks++; if (bus_all !== 53'd0 || rsp_data !== d[0]) begin errors++;
            $display("FAIL hold_release got=%h/%h exp=0/%h", bus_all, rsp_data, d[0]); end
        for (int b = 1; b < 4; b++) begin
            next_cycle(); bus_ack = 1'b1; bus_q = d[b]; #1;
            checks++; if (bus_all !== {1'b1, 1'b1, 1'b0, 2'b00, 16'(16 + b), 32'h0}) begin errors++;
                $display("FAIL hold_beat%0d got=%h", b, bus_all); end
            if (b > 1) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== d[b-1]) begin errors++;
                    $display("FAIL hold_data%0d got=%b/%h exp=1/%h", b - 1, rsp_valid, rsp_data, d[b-1]); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got=%b exp=0", rsp_valid); end
            end
        end
        next_cycle(); bus_ack = 1'b0; bus_sel = 1'b0; #1;
        checks++; if ({rsp_valid, done} !== 2'b11 || rsp_data !== d[3]) begin errors++;
            $display("FAIL hold_last got=%b/%h exp=11/%h", {rsp_valid, done}, rsp_data, d[3]); end
        next_cycle(); rsp_ready = 1'b0; #1;
        checks++; if ({rsp_valid, done, busy} !== 3'b000) begin errors++;
            $display("FAIL hold_end got=%b exp=000", {rsp_valid, done, busy}); end
    endtask

    task automatic test_timeout();
        int err_at, err_cnt, busy_cnt, done_cnt;
        err_at = -1; err_cnt = 0; busy_cnt = 0; done_cnt = 0;
        issue(1'b1, 2'b10, 16'h0400, 32'hA5A5A5A5, 8'd3);
        bus_sel = 1'b0; bus_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) next_cycle();
            #1;
            checks++; if (bus_all !== 53'd0) begin errors++; $display("FAIL to_bus%0d got=%h exp=0", i, bus_all); end
            if (err === 1'b1) begin err_cnt++; if (err_at < 0) err_at = i; end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (err_at !== 8) begin errors++; $display("FAIL to_err_cycle got=%0d exp=8", err_at); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err_width got=%0d exp=1", err_cnt); end
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL to_busy_cycles got=%0d exp=8", busy_cnt); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL to_done got=%0d exp=0", done_cnt); end
        // Ack arriving in the last allowed cycle of each beat still completes.
        rsp_ready = 1'b1;
        issue(1'b0, 2'b00, 16'h0050, 32'h0, 8'd1);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cycle();
            bus_sel = 1'b1; bus_ack = ((c % 8) == 7); bus_q = 32'h1000 + 32'(c); #1;
            checks++; if ({bus_r, err} !== 2'b10) begin errors++; $display("FAIL to_edge%0d got=%b exp=10", c, {bus_r, err}); end
        end
        next_cycle(); bus_sel = 1'b0; bus_ack = 1'b0; #1;
        checks++; if ({done, err} !== 2'b10 || rsp_data !== 32'h100F) begin errors++;
            $display("FAIL to_edge_done got=%b/%h exp=10/0000100f", {done, err}, rsp_data); end
        next_cycle(); rsp_ready = 1'b0;
    endtask

    task automatic test_bad_size();
        next_cycle(); bus_sel = 1'b1; bus_ack = 1'b1; cmd_valid = 1'b1; cmd_size = 2'b11;
        cmd_wr = 1'b1; cmd_addr = 16'h1234; cmd_len = 8'd4; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bad_ready got=%b exp=1", cmd_ready); end
        next_cycle(); cmd_valid = 1'b0; #1;
        checks++; if ({err, done, busy, cmd_ready} !== 4'b1001) begin errors++;
            $display("FAIL bad_err got=%b exp=1001", {err, done, busy, cmd_ready}); end
        checks++; if (bus_all !== 53'd0) begin errors++; $display("FAIL bad_bus got=%h exp=0", bus_all); end
        next_cycle(); #1;
        checks++; if ({err, done, rsp_valid} !== 3'b000 || bus_all !== 53'd0) begin errors++;
            $display("FAIL bad_after got=%b/%h exp=000/0", {err, done, rsp_valid}, bus_all); end
        cmd_size = 2'b00; bus_sel = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_reset_midburst();
        rsp_ready = 1'b1;
        issue(1'b0, 2'b10, 16'h2000, 32'h0, 8'd3);
        bus_sel = 1'b1; bus_ack = 1'b1; bus_q = $urandom; #1;
        checks++; if (bus_a !== 16'h2000) begin errors++; $display("FAIL mid_beat1 got=%h exp=2000", bus_a); end
        next_cycle(); bus_ack = 1'b0; #1;
        checks++; if (bus_all !== {1'b1, 1'b1, 1'b0, 2'b10, 16'h2004, 32'h0}) begin errors++;
            $display("FAIL mid_beat2 got=%h", bus_all); end
        #2; nres = 1'b0; #1;
        checks++; if (bus_all !== 53'd0) begin errors++; $display("FAIL mid_rst_bus got=%h exp=0", bus_all); end
        checks++; if ({rsp_valid, done, err, busy, cmd_ready} !== 5'd0 || rsp_data !== 32'd0) begin errors++;
            $display("FAIL mid_rst_flags got=%b/%h exp=00000/0", {rsp_valid, done, err, busy, cmd_ready}, rsp_data); end
        next_cycle(); next_cycle(); nres = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle(); bus_ack = 1'b1; #1;
            checks++; if ({done, err, rsp_valid, cmd_ready} !== 4'b0001 || bus_all !== 53'd0) begin errors++;
                $display("FAIL mid_after%0d got=%b/%h exp=0001/0", i, {done, err, rsp_valid, cmd_ready}, bus_all); end
        end
        bus_sel = 1'b0; bus_ack = 1'b0; rsp_ready = 1'b0;
    endtask

    // Random bursts against a beat-level model: which beat is being
    // requested, whether a response is owed, and what data it must carry.
    task automatic test_random();
        logic        wr, req, hold, pend, done_exp, fin, sel, rdy, ack;
        logic [1:0]  size;
        logic [7:0]  len;
        logic [15:0] addr0;
        logic [31:0] data, q;
        logic [52:0] exp_bus;
        logic [31:0] exp_q[$];
        int          step, addr_i, beat, wt, cyc;
        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 2));
            len = 8'($urandom_range(0, 5)); data = $urandom;
            addr0 = ($urandom_range(0, 2) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            step = 1 << size; addr_i = addr0;
            next_cycle();
            cmd_valid = 1'b1; cmd_wr = wr; cmd_size = size; cmd_addr = addr0; cmd_data = data; cmd_len = len;
            bus_sel = 1'($urandom_range(0, 1)); bus_ack = 1'b0; rsp_ready = 1'b1; #1;
            checks++; if ({cmd_ready, busy, done, err} !== 4'b1000 || bus_all !== 53'd0) begin errors++;
                $display("FAIL rnd%0d_issue got=%b/%h exp=1000/0", t, {cmd_ready, busy, done, err}, bus_all); end
            req = 1'b1; hold = 1'b0; pend = 1'b0; done_exp = 1'b0; fin = 1'b0;
            beat = 0; wt = 0; cyc = 0; exp_q.delete();
            while (!(fin && !pend && !done_exp) && cyc < 200) begin
                next_cycle(); cmd_valid = 1'b0;
                sel = 1'($urandom_range(0, 1)); rdy = ($urandom_range(0, 3) != 0); ack = 1'b0; q = $urandom;
                if (req) begin
                    if (wt >= 4) begin sel = 1'b1; rdy = 1'b1; ack = 1'b1; end
                    else if (sel && (!pend || rdy) && $urandom_range(0, 1) == 1) ack = 1'b1;
                end else begin
                    ack = ($urandom_range(0, 3) == 0);
                end
                bus_sel = sel; bus_ack = ack; bus_q = q; rsp_ready = rdy; #1;
                exp_bus = (req && sel) ? {1'b1, 1'b1, wr, size, 16'(addr_i), wr ? data : 32'h0} : 53'd0;
                checks++; if (bus_all !== exp_bus) begin errors++;
                    $display("FAIL rnd%0d_bus c%0d got=%h exp=%h", t, cyc, bus_all, exp_bus); end
                checks++; if ({rsp_valid, done, err, busy} !== {pend, done_exp, 1'b0, req | hold | pend}) begin errors++;
                    $display("FAIL rnd%0d_flags c%0d got=%b exp=%b", t, cyc, {rsp_valid, done, err, busy},
                             {pend, done_exp, 1'b0, req | hold | pend}); end
                if (pend && rdy) begin
                    checks++; if (rsp_data !== exp_q[0]) begin errors++;
                        $display("FAIL rnd%0d_data c%0d got=%h exp=%h", t, cyc, rsp_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                done_exp = 1'b0;
                if (req && ack) begin
                    if (!wr) exp_q.push_back(q);
                    if (beat == int'(len)) begin
                        fin = 1'b1; req = 1'b0; done_exp = 1'b1;
                    end else begin
                        beat++; addr_i = (addr_i + step) % 65536; wt = 0;
                        if (!wr && !rdy) begin hold = 1'b1; req = 1'b0; end
                    end
                end else if (req) begin
                    wt++;
                end else if (hold && rdy) begin
                    hold = 1'b0; req = 1'b1; wt = 0;
                end
                pend = (exp_q.size() != 0);
                cyc++;
            end
            if (cyc >= 200) begin
                checks++; errors++; $display("FAIL rnd%0d_budget cycles=%0d limit=200", t, cyc);
            end
        end
        bus_sel = 1'b0; bus_ack = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_long();
        test_write_burst();
        test_read_hold();
        test_timeout();
        test_bad_size();
        test_reset_midburst();
        test_random();
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

endmodule
